cse_axis_packer: RTL
====================

// Module: cse_axis_packer
// PURPOSE
//  Drains the compressed-stream-element (CSE) holding register of the compression stage onto an
//  AXI4-Stream master, SHIFTLENGTH_BYTES per beat. Pulses CSEShift as each beat is captured.
//  Marks the last beat of each element with TLAST/TKEEP.
//  Tells the upstream stage when the CSE register is free for the next uncompressed element.
// PARAMETERS
//  MAX_COMPRESSED_STREAM_ELEMENT_LENGTH_BYTES  34  width in bytes of CSEData from upstream
//  SHIFTLENGTH_BYTES                           8   bytes per AXIS beat; must match upstream shift
//  STAT_WIDTH                                  32  width of element/byte statistics counters
// PORTS
//  clk             in   1        clock, all logic on rising edge
//  reset           in   1        asynchronous, active-high reset
//  CSEData         in   MAXC*8   upstream CSE register; byte 0 = CSEData[7:0] is sent first
//  CSEByteCount    in   clog2(MAXC)  valid bytes remaining in CSEData; 0 = empty
//  CSEShift        out  1        combinational; upstream drops SHIFTLENGTH_BYTES bytes at next edge
//  USEReady        out  1        registered; upstream may load a new element this cycle
//  m_axis_tdata    out  SL*8     beat data, byte i in tdata[8i+7:8i]
//  m_axis_tkeep    out  SL       byte enables, contiguous from bit 0
//  m_axis_tlast    out  1        last beat of current element
//  m_axis_tvalid   out  1        beat valid
//  m_axis_tready   in   1        downstream accepts beat
//  ElementsSent    out  STAT_WIDTH  count of TLAST beats accepted, wraps modulo 2^STAT_WIDTH
//  BytesSent       out  STAT_WIDTH  sum of popcount(tkeep) over accepted beats, wraps
// BEHAVIOUR
//  Reset values: tvalid=0, tdata=0, tkeep=0, tlast=0, USEReady=0, counters=0, state=IDLE.
//  CSEShift=0 while reset is high.
//  Output register ("slot") holds one beat; slot_free = !tvalid | tready.
//  Capture condition cap = (state!=IDLE_WAIT) & (CSEByteCount!=0) & slot_free; CSEShift = cap.
//  On cap at edge:
//   - tdata <= CSEData[SL-1:0]
//   - n = min(CSEByteCount, SL); tkeep <= (1<<n)-1
//   - tlast <= (CSEByteCount <= SL); tvalid <= 1
//  No cap and tready: tvalid <= 0; tdata/tkeep/tlast hold.
//  Throughput is 1 beat/clk while tready=1. Latency is CSEByteCount!=0 -> tvalid one clk.
//  tdata/tkeep/tlast are stable while tvalid & !tready (AXIS rule); CSEShift=0 in that case.
//  State machine:
//   IDLE:      slot empty, count==0. USEReady=1.
//              -> BUSY when CSEByteCount!=0 (element loaded).
//   BUSY:      capturing beats. USEReady=0.
//              -> DRAIN on cap with tlast-beat.
//   DRAIN:     last beat in slot, upstream count now 0. USEReady=0.
//              -> IDLE when the tlast beat is accepted (tvalid & tready).
//   IDLE_WAIT: one clk after IDLE's USEReady, absorbs upstream load latency; no cap.
//              -> BUSY if count!=0, else IDLE.
//  USEReady is registered: high only in IDLE. Upstream load overrides shift, so no load is
//  permitted while BUSY/DRAIN. A load seen outside IDLE/IDLE_WAIT is a protocol error (ignored).
//  Element boundary: the next element's first beat never shares a beat with the previous
//  element; minimum one idle tvalid gap between elements is allowed.
//  Count exactly SL: single beat, tkeep all ones, tlast=1. Count 0: no beat ever issued.
//  Counters update on accepted beats only (tvalid & tready). STAT_WIDTH wrap is silent.
//  Asynchronous reset mid-element: tvalid drops immediately and the partial element is lost.
//  Upstream is reset by the same signal.
// TESTING
//  1. Load count=20 (bytes 0x00..0x13), tready=1 -> beats on 3 consecutive clks:
//     - tkeep FF/FF/0F, tlast 0/0/1
//     - data 0x0706..00, 0x0F0E..08, 0x..13121110
//     ElementsSent=1, BytesSent=20.
//  2. count=8 -> single beat tkeep=FF tlast=1; count=1 -> tkeep=01 tlast=1; count=0 -> no tvalid.
//  3. count=34, tready toggling 1,0,0,1,...:
//     - tdata/tkeep stable while stalled; CSEShift only when slot_free
//     - 5 beats, last tkeep=03; BytesSent=34
//  4. Back-to-back elements 16 then 9:
//     - USEReady low from load to last accept; second element starts only after IDLE
//     - tlast on beat 2 and beat 4
//  5. Assert reset during beat 2 of a 34-byte element with tready=0 -> tvalid=0 same cycle;
//     all outputs at reset values; after release a fresh 4-byte element sends tkeep=0F tlast=1.
//  6. Preload ElementsSent=2^32-1 via force -> next tlast accept wraps it to 0.

Source files
------------

// File: rtl/cse_axis_packer.sv
`default_nettype none
// cse_axis_packer: drains the upstream CSE holding register onto an AXI4-Stream master,
// SHIFTLENGTH_BYTES per beat, marking each element's final beat with TLAST/TKEEP.
module cse_axis_packer #(
  parameter int MAX_COMPRESSED_STREAM_ELEMENT_LENGTH_BYTES = 34,
  parameter int SHIFTLENGTH_BYTES                          = 8,
  parameter int STAT_WIDTH                                 = 32,
  localparam int MAXC = MAX_COMPRESSED_STREAM_ELEMENT_LENGTH_BYTES,
  localparam int SL   = SHIFTLENGTH_BYTES,
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1,
  localparam int PW   = $clog2(SL + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MAXC*8-1:0]     CSEData,
  input  logic [CW-1:0]         CSEByteCount,
  output logic                  CSEShift,
  output logic                  USEReady,
  output logic [SL*8-1:0]       m_axis_tdata,
  output logic [SL-1:0]         m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [STAT_WIDTH-1:0] ElementsSent,
  output logic [STAT_WIDTH-1:0] BytesSent
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BUSY      = 2'd1,
    S_DRAIN     = 2'd2,
    S_IDLE_WAIT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SL*8-1:0]       tdata_q;
  logic [SL-1:0]         tkeep_q;
  logic                  tlast_q;
  logic                  tvalid_q;
  logic                  use_ready_q;
  logic [STAT_WIDTH-1:0] elements_q;
  logic [STAT_WIDTH-1:0] bytes_q;

  logic                  cnt_nz;
  logic                  last_beat;
  logic                  slot_free;
  logic                  cap;
  logic                  accept;
  logic [SL-1:0]         keep_d;
  logic [PW-1:0]         keep_pop;

  // Only the low beat of the CSE register is ever presented; upstream shifts the rest down.
  generate
    if (MAXC > SL) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^CSEData[MAXC*8-1:SL*8];
    end
  endgenerate

  assign cnt_nz    = (CSEByteCount != '0);
  assign last_beat = (32'(CSEByteCount) <= 32'(SL));
  assign slot_free = !tvalid_q || m_axis_tready;
  assign accept    = tvalid_q && m_axis_tready;
  assign cap       = !reset && (state_q != S_IDLE_WAIT) && cnt_nz && slot_free;

  always_comb begin
    keep_d = '0;
    for (int i = 0; i < SL; i++) begin
      keep_d[i] = (32'(CSEByteCount) > 32'(i));
    end
  end

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < SL; i++) begin
      keep_pop = keep_pop + PW'(tkeep_q[i]);
    end
  end

  // IDLE offers USEReady for a single cycle; IDLE_WAIT then covers the upstream load.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cnt_nz) begin
          state_d = (cap && last_beat) ? S_DRAIN : S_BUSY;
        end else begin
          state_d = S_IDLE_WAIT;
        end
      end
      S_IDLE_WAIT: state_d = cnt_nz ? S_BUSY : S_IDLE;
      S_BUSY: begin
        if (cap && last_beat) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept && tlast_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      use_ready_q <= 1'b0;
      elements_q  <= '0;
      bytes_q     <= '0;
    end else begin
      state_q     <= state_d;
      use_ready_q <= (state_d == S_IDLE);
      if (cap) begin
        tdata_q  <= CSEData[SL*8-1:0];
        tkeep_q  <= keep_d;
        tlast_q  <= last_beat;
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
      if (accept) begin
        bytes_q <= bytes_q + STAT_WIDTH'(keep_pop);
        if (tlast_q) begin
          elements_q <= elements_q + STAT_WIDTH'(1);
        end
      end
    end
  end

  assign CSEShift      = cap;
  assign USEReady      = use_ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign ElementsSent  = elements_q;
  assign BytesSent     = bytes_q;

endmodule
`default_nettype wire
